// File: rtl/bg_sequencer.sv
// Plays a stored sequence of 3-bit background codes onto the background mux select.
// Latency: start accepted at edge T shows mem[0] from T+1; each step is ON_CYCLES on, OFF_CYCLES gap.
// Backpressure: none; start is taken only in IDLE and abort wins over start.
// Ports: clk/rst_n; wr_en/wr_addr/wr_data program the sequence memory; start/len/abort control
// playback; bg/step/busy/done are registered status outputs.
module bg_sequencer #(
    parameter int          MAX_LEN    = 16,
    parameter int          ON_CYCLES  = 25000000,
    parameter int          OFF_CYCLES = 12500000,
    parameter logic [2:0]  IDLE_BG    = 3'd0,
    localparam int         AW         = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    wr_data,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          abort,
    output logic [2:0]    bg,
    output logic [AW-1:0] step,
    output logic          busy,
    output logic          done
);

    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   LEN_MAX  = (AW + 1)'(MAX_LEN);
    localparam logic [AW:0]   LEN_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW:0]   len_q;
    logic [2:0]    mem [MAX_LEN];

    logic          len_ok;
    logic          last_step;
    logic [AW-1:0] next_idx;

    assign len_ok    = (len != '0) && (len <= LEN_MAX);
    // step doubles as the playback index, so the last-step test compares it against len_q-1
    assign last_step = ({1'b0, step} == (len_q - LEN_ONE));
    assign next_idx  = step + IDX_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            len_q <= '0;
            bg    <= IDLE_BG;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                mem[i] <= 3'd0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort && len_ok) begin
                        state <= S_ON;
                        len_q <= len;
                        cnt   <= '0;
                        step  <= '0;
                        busy  <= 1'b1;
                        // memory is sampled only here, so a same-edge write is not seen
                        bg    <= mem[0];
                    end
                end
                S_ON: begin
                    if (abort) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        step  <= '0;
                        busy  <= 1'b0;
                        bg    <= IDLE_BG;
                    end else if (cnt == ON_LAST) begin
                        state <= S_OFF;
                        cnt   <= '0;
                        bg    <= IDLE_BG;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                S_OFF: begin
                    if (abort) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        step  <= '0;
                        busy  <= 1'b0;
                        bg    <= IDLE_BG;
                    end else if (cnt == OFF_LAST) begin
                        cnt <= '0;
                        if (last_step) begin
                            state <= S_IDLE;
                            step  <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ON;
                            step  <= next_idx;
                            bg    <= mem[next_idx];
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    step  <= '0;
                    busy  <= 1'b0;
                    bg    <= IDLE_BG;
                end
            endcase

            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: doc/bg_sequencer.md
# bg_sequencer

Playback controller for the background colour mux in the Simon game. It holds a programmable sequence of up to MAX_LEN 3-bit background codes and, on a start request, drives the mux select through that sequence. Each step flashes for ON_CYCLES, followed by an IDLE_BG gap of OFF_CYCLES. It sits between the game FSM, which writes the sequence and issues start/abort, and the background mux select input.

## Interface
- MAX_LEN, 16: sequence capacity in steps; power of two, ≥2; AW = clog2(MAX_LEN).
- ON_CYCLES, 25000000: clock cycles each step's colour is shown; ≥1.
- OFF_CYCLES, 12500000: clock cycles of IDLE_BG gap after each step; ≥1.
- IDLE_BG, 0: 3-bit background code driven when idle or in a gap.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe for sequence memory.
- wr_addr  in  AW  step index to write.
- wr_data  in  3  background code to store.
- start  in  1  play request; sampled only in IDLE.
- len  in  AW+1  number of steps to play; valid range 1..MAX_LEN.
- abort  in  1  stop playback immediately.
- bg  out  3  background select to the mux; registered.
- step  out  AW  index of the current step; 0 when idle.
- busy  out  1  high while playing.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- Reset: bg=IDLE_BG, step=0, busy=0, done=0, all memory entries=0, state IDLE, counters 0.
- Memory: MAX_LEN×3 register array.
  - Written when wr_en=1, in any state.
  - Read only at entry to ON.
  - A write to the step currently showing does not change bg until that index is replayed.
- State IDLE: bg=IDLE_BG, busy=0.
  - start=1 with 1≤len≤MAX_LEN: latch len, set idx=0, enter ON.
  - start with len=0 or len>MAX_LEN is ignored; no busy, no done.
- State ON: bg=mem[idx], busy=1, step=idx.
  - Runs for exactly ON_CYCLES cycles, then enters OFF.
- State OFF: bg=IDLE_BG, busy=1, step=idx.
  - Runs for exactly OFF_CYCLES cycles.
  - If idx==len_q−1: enter IDLE and pulse done. Otherwise idx+1 and enter ON.
- start while busy: ignored. A changing len input while busy: ignored, because the latched len_q is used.
- abort=1 in ON or OFF: next cycle enters IDLE with bg=IDLE_BG, busy=0, step=0; no done. abort in IDLE has no effect.
- abort and start in the same IDLE cycle: abort wins; start is ignored.
- Counter width: clog2(max(ON_CYCLES,OFF_CYCLES)+1). The counter resets to 0 on every state entry; no wrap.
- Reset asserted mid-playback: outputs return to reset values asynchronously; memory is cleared.

## Timing
- Start accepted at edge T (IDLE, start=1, valid len).
  - From T+1: busy=1 and bg=mem[0].
  - bg changes to IDLE_BG after ON_CYCLES cycles.
  - Step k colour begins at T+1+k·(ON_CYCLES+OFF_CYCLES).
- Done timing:
  - done=1 for exactly one cycle starting T+1+len·(ON_CYCLES+OFF_CYCLES).
  - In that same cycle busy=0, step=0 and bg=IDLE_BG.
  - Total busy cycles = len·(ON_CYCLES+OFF_CYCLES).
- Back-to-back: a start asserted in the done cycle is accepted; the next playback begins one cycle later.
- Write latency: a write at edge W is visible to an ON entry at edge W+1 or later.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle: hold rst_n=0, then release with no stimulus → bg=0, busy=0, done=0, step=0 for 20 cycles.
- Basic playback (ON=3, OFF=2):
  - Write mem[0..3]=5,2,7,1; start with len=4.
  - bg reads 5,5,5,0,0,2,2,2,0,0,7,7,7,0,0,1,1,1,0,0.
  - busy is high for exactly 20 cycles; step=0,1,2,3 per step; a single done pulse at cycle 21.
- Illegal/ignored requests:
  - start with len=0 and with len=17 → no busy, no done.
  - start again mid-play → timing is unchanged from the basic-playback case.
- Abort in the second step's ON phase → next cycle busy=0, bg=0, step=0, no done; a following start replays from step 0.
- Write during play: during step 1, overwrite mem[1]=3 and mem[2]=6 → step 1 keeps its original colour 2; step 2 shows 6.
- Back-to-back and async reset:
  - start (len=1) in the done cycle → new playback begins next cycle.
  - Assert rst_n=0 mid-OFF → busy and bg clear immediately, without waiting for a clock edge; memory reads back 0 after a new start.
